// File: rtl/amiga_clkgen_pkg.sv
// amiga_clkgen_pkg: shared FSM states, default timing parameters and width helper
package amiga_clkgen_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DONE} esync_state_t;
    localparam int DIV_DEF    = 4;
    localparam int E_DIV_DEF  = 10;
    localparam int E_HIGH_DEF = 4;
    function automatic int clog2(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/amiga_clkgen_esync.sv
// amiga_clkgen_esync: E-synchronous access handshake (e_req -> wait rise -> active -> ack at fall)
//   clk_28/reset: master clock, sync active-high reset
//   clk7_en, eclk_rise, eclk_fall: timing pulses from the generator; e_req/e_ack: request/done levels
module amiga_clkgen_esync import amiga_clkgen_pkg::*; (
    input  logic clk_28,
    input  logic reset,
    input  logic clk7_en,
    input  logic eclk_rise,
    input  logic eclk_fall,
    input  logic e_req,
    output logic e_ack
);
    esync_state_t state, state_nx;
    always_ff @(posedge clk_28) begin
        if (reset) begin
            state <= IDLE;
            e_ack <= 1'b0;
        end else begin
            state <= state_nx;
            e_ack <= (state_nx == DONE);
        end
    end
    always_comb begin
        state_nx = state;
        if (clk7_en)
            case (state)
                IDLE:    state_nx = e_req ? WAIT : IDLE;
                WAIT:    state_nx = !e_req ? IDLE : eclk_rise ? ACTIVE : WAIT;
                ACTIVE:  state_nx = eclk_fall ? DONE : ACTIVE;
                default: state_nx = e_req ? DONE : IDLE;
            endcase
    end
endmodule

// File: rtl/amiga_clkgen.sv
// amiga_clkgen: 7 MHz enables, c1/c3 quadrature, CCK, asymmetric E-clock and E-sync handshake
//   clk_28/reset: master clock, sync active-high reset; run: 1 = advance, 0 = freeze
//   clk7_en/clk7n_en: 7 MHz edge enables; c1/c3: quadrature levels; cck: colour clock
//   eclk/eclk_rise/eclk_fall: E-clock level and edge pulses; e_req/e_ack: CIA access handshake
//   AMIGA_CLKGEN_ECLK_VEC_EN adds eclk_vec, a registered one-hot of the E phase
module amiga_clkgen import amiga_clkgen_pkg::*; #(
    parameter int DIV    = DIV_DEF,
    parameter int E_DIV  = E_DIV_DEF,
    parameter int E_HIGH = E_HIGH_DEF
) (
    input  logic clk_28,
    input  logic reset,
    input  logic run,
    output logic clk7_en,
    output logic clk7n_en,
    output logic c1,
    output logic c3,
    output logic cck,
    output logic eclk,
    output logic eclk_rise,
    output logic eclk_fall,
    input  logic e_req,
    output logic e_ack
`ifdef AMIGA_CLKGEN_ECLK_VEC_EN
    ,
    output logic [E_DIV-1:0] eclk_vec
`endif
);
    localparam int CW = clog2(DIV);
    localparam int EW = clog2(E_DIV);
    logic [CW-1:0] cnt;
    logic [EW-1:0] e_ph, e_ph_nx;
    logic tick7;
    assign tick7   = run && cnt == CW'(DIV - 1);
    assign e_ph_nx = tick7 ? ((e_ph == EW'(E_DIV - 1)) ? '0 : e_ph + 1'b1) : e_ph;
    always_ff @(posedge clk_28) begin
        if (reset) begin
            cnt       <= '0;
            e_ph      <= '0;
            clk7_en   <= 1'b0;
            clk7n_en  <= 1'b0;
            c1        <= 1'b0;
            c3        <= 1'b0;
            cck       <= 1'b1;
            eclk      <= 1'b0;
            eclk_rise <= 1'b0;
            eclk_fall <= 1'b0;
        end else begin
            cnt       <= run ? ((cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1) : cnt;
            clk7_en   <= tick7;
            clk7n_en  <= run && cnt == CW'(DIV / 2 - 1);
            c3        <= cnt >= CW'(DIV / 2);
            c1        <= ~c3;
            cck       <= cck ^ tick7;
            e_ph      <= e_ph_nx;
            eclk      <= e_ph_nx >= EW'(E_DIV - E_HIGH);
            eclk_rise <= tick7 && e_ph_nx == EW'(E_DIV - E_HIGH);
            eclk_fall <= tick7 && e_ph_nx == '0;
        end
    end
`ifdef AMIGA_CLKGEN_ECLK_VEC_EN
    always_ff @(posedge clk_28) begin
        if (reset)
            eclk_vec <= E_DIV'(1);
        else if (tick7)
            eclk_vec <= {eclk_vec[E_DIV-2:0], eclk_vec[E_DIV-1]};
    end
`endif
    // The registered clk7_en pulse outlives the run edge by one tick; gating keeps the FSM frozen.
    amiga_clkgen_esync u_esync (
        .clk_28    (clk_28),
        .reset     (reset),
        .clk7_en   (clk7_en && run),
        .eclk_rise (eclk_rise),
        .eclk_fall (eclk_fall),
        .e_req     (e_req),
        .e_ack     (e_ack)
    );
endmodule

// File: tb/tb_amiga_clkgen.sv
// tb_amiga_clkgen: directed plus random checks of two amiga_clkgen configurations against a counting model
module tb_amiga_clkgen;
    logic clk_28 = 1'b0, reset, run, e_req;
    logic a_clk7_en, a_clk7n_en, a_c1, a_c3, a_cck, a_eclk, a_eclk_rise, a_eclk_fall, a_e_ack;
    logic b_clk7_en, b_clk7n_en, b_c1, b_c3, b_cck, b_eclk, b_eclk_rise, b_eclk_fall, b_e_ack;
`ifdef AMIGA_CLKGEN_ECLK_VEC_EN
    logic [9:0] a_eclk_vec;
    logic [7:0] b_eclk_vec;
`endif
    int checks = 0, errors = 0;
    int n, fa, fb, la, lb, pa, pb, ra, rb, fla, flb, ha, hb, hi;
    logic pf, pc;
    logic [1:0] snap_lv, snap_q;

    always #5 clk_28 = ~clk_28;

    amiga_clkgen u_a (
        .clk_28(clk_28), .reset(reset), .run(run),
        .clk7_en(a_clk7_en), .clk7n_en(a_clk7n_en), .c1(a_c1), .c3(a_c3), .cck(a_cck),
        .eclk(a_eclk), .eclk_rise(a_eclk_rise), .eclk_fall(a_eclk_fall),
        .e_req(e_req), .e_ack(a_e_ack)
`ifdef AMIGA_CLKGEN_ECLK_VEC_EN
        , .eclk_vec(a_eclk_vec)
`endif
    );

    amiga_clkgen #(.DIV(6), .E_DIV(8), .E_HIGH(3)) u_b (
        .clk_28(clk_28), .reset(reset), .run(run),
        .clk7_en(b_clk7_en), .clk7n_en(b_clk7n_en), .c1(b_c1), .c3(b_c3), .cck(b_cck),
        .eclk(b_eclk), .eclk_rise(b_eclk_rise), .eclk_fall(b_eclk_fall),
        .e_req(e_req), .e_ack(b_e_ack)
`ifdef AMIGA_CLKGEN_ECLK_VEC_EN
        , .eclk_vec(b_eclk_vec)
`endif
    );

    // Model: k counts running ticks, p7 counts 7 MHz pulses; every level is derived from those.
    // hs: 0 no request, 1 waiting for E rise, 2 inside E high, 3 acknowledged.
    typedef struct {
        int k; int p7; int hs;
        bit clk7, clk7n, c1, c3, cck, eclk, rise, fall, ack;
    } m_t;
    m_t ma, mb;

    function automatic m_t nxt(m_t m, int div, int ediv, int ehigh, bit rst, bit rn, bit req);
        m_t r = m;
        int eph;
        if (rst) begin
            r = '{default: 0};
            r.cck = 1'b1;
            return r;
        end
        r.c3 = (m.k % div) >= div / 2;
        r.c1 = !m.c3;
        if (rn && m.clk7) begin
            if (m.hs == 0 && req) r.hs = 1;
            else if (m.hs == 1) r.hs = !req ? 0 : (m.rise ? 2 : 1);
            else if (m.hs == 2 && m.fall) r.hs = 3;
            else if (m.hs == 3 && !req) r.hs = 0;
        end
        r.ack   = r.hs == 3;
        r.clk7  = rn && (m.k % div == div - 1);
        r.clk7n = rn && (m.k % div == div / 2 - 1);
        if (rn) r.k = m.k + 1;
        if (r.clk7) r.p7 = m.p7 + 1;
        eph    = r.p7 % ediv;
        r.cck  = (r.p7 % 2) == 0;
        r.eclk = eph >= ediv - ehigh;
        r.rise = r.clk7 && eph == ediv - ehigh;
        r.fall = r.clk7 && eph == 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_all();
        chk("a_outs", {a_clk7_en, a_clk7n_en, a_c1, a_c3, a_cck, a_eclk, a_eclk_rise, a_eclk_fall, a_e_ack},
            {ma.clk7, ma.clk7n, ma.c1, ma.c3, ma.cck, ma.eclk, ma.rise, ma.fall, ma.ack});
        chk("b_outs", {b_clk7_en, b_clk7n_en, b_c1, b_c3, b_cck, b_eclk, b_eclk_rise, b_eclk_fall, b_e_ack},
            {mb.clk7, mb.clk7n, mb.c1, mb.c3, mb.cck, mb.eclk, mb.rise, mb.fall, mb.ack});
`ifdef AMIGA_CLKGEN_ECLK_VEC_EN
        chk("a_vec", a_eclk_vec, 32'd1 << (ma.p7 % 10));
        chk("b_vec", b_eclk_vec, 32'd1 << (mb.p7 % 8));
        chk("b_vec_onehot", $onehot(b_eclk_vec), 1);
`endif
    endtask

    task automatic tick();
        @(posedge clk_28);
        ma = nxt(ma, 4, 10, 4, reset, run, e_req);
        mb = nxt(mb, 6, 8, 3, reset, run, e_req);
        #1;
        cmp_all();
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; e_req = 1'b0;
        repeat (3) tick();
        chk("rst_a", {a_clk7_en, a_clk7n_en, a_c1, a_c3, a_cck, a_eclk, a_eclk_rise, a_eclk_fall, a_e_ack}, 9'b000010000);
        chk("rst_b", {b_clk7_en, b_clk7n_en, b_c1, b_c3, b_cck, b_eclk, b_eclk_rise, b_eclk_fall, b_e_ack}, 9'b000010000);

        reset = 1'b0; run = 1'b1;
        n = 0; fa = 0; fb = 0;
        while ((fa == 0 || fb == 0) && n < 20) begin
            tick(); n++;
            if (a_clk7_en && fa == 0) fa = n;
            if (b_clk7_en && fb == 0) fb = n;
        end
        chk("first_clk7_a", fa, 4);
        chk("first_clk7_b", fb, 6);

        la = fa; lb = fb; pa = 0; pb = 0; ra = 0; rb = 0; fla = 0; flb = 0; ha = 0; hb = 0;
        repeat (240) begin
            tick(); n++;
            if (a_clk7_en) begin chk("period_a", n - la, 4); la = n; pa++; end
            if (b_clk7_en) begin chk("period_b", n - lb, 6); lb = n; pb++; end
            ra += a_eclk_rise; rb += b_eclk_rise; fla += a_eclk_fall; flb += b_eclk_fall;
            ha += a_eclk; hb += b_eclk;
        end
        chk("pulses_a", pa, 60);
        chk("pulses_b", pb, 40);
        chk("e_high_a", ha, 96);
        chk("e_high_b", hb, 90);
        chk("e_edges_a", {ra[7:0], fla[7:0]}, {8'd6, 8'd6});
        chk("e_edges_b", {rb[7:0], flb[7:0]}, {8'd5, 8'd5});

        n = 0;
        while (!(ma.clk7 && ma.p7 % 10 == 4) && n < 100) begin tick(); n++; end
        chk("sync_found", ma.clk7 && ma.p7 % 10 == 4, 1);
        e_req = 1'b1; n = 0; pf = 1'b0;
        while (!a_e_ack && n < 100) begin pf = a_eclk_fall; tick(); n++; end
        chk("ack_latency", n, 25);
        chk("ack_after_fall", pf, 1);
        e_req = 1'b0; n = 0; pc = 1'b0;
        while (a_e_ack && n < 20) begin pc = a_clk7_en; tick(); n++; end
        chk("ack_drop_latency", n, 4);
        chk("ack_drop_after_clk7", pc, 1);

        repeat (600) begin
            reset = $urandom_range(0, 99) == 0;
            run   = $urandom_range(0, 3) != 0;
            e_req = $urandom_range(0, 1) == 1;
            tick();
        end

        reset = 1'b0; run = 1'b1; e_req = 1'b0; n = 0;
        while (!a_eclk_rise && n < 100) begin tick(); n++; end
        chk("rise_found", a_eclk_rise, 1);
        hi = 1;
        repeat (6) begin tick(); hi += a_eclk; end
        run = 1'b0;
        snap_lv = {a_cck, a_eclk};
        for (int i = 0; i < 13; i++) begin
            tick();
            chk("pause_pulses", {a_clk7_en, a_clk7n_en, a_eclk_rise, a_eclk_fall}, 4'b0000);
            chk("pause_levels", {a_cck, a_eclk}, snap_lv);
            if (i == 2) snap_q = {a_c1, a_c3};
            if (i > 2) chk("pause_quad", {a_c1, a_c3}, snap_q);
        end
        run = 1'b1; n = 0;
        while (n < 60) begin
            tick(); n++;
            if (!a_eclk) break;
            hi++;
        end
        chk("high_time", hi, 16);

        e_req = 1'b1; n = 0;
        while (!(ma.hs == 2 && a_eclk_fall) && n < 200) begin tick(); n++; end
        chk("ack_pending", ma.hs == 2 && a_eclk_fall, 1);
        reset = 1'b1;
        tick();
        chk("rst_mid_ack", a_e_ack, 0);
        chk("rst_mid_a", {a_clk7_en, a_clk7n_en, a_c1, a_c3, a_cck, a_eclk, a_eclk_rise, a_eclk_fall, a_e_ack}, 9'b000010000);
        chk("rst_mid_b", {b_clk7_en, b_clk7n_en, b_c1, b_c3, b_cck, b_eclk, b_eclk_rise, b_eclk_fall, b_e_ack}, 9'b000010000);
        tick();
        reset = 1'b0; e_req = 1'b0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
